fp_norm_pack: RTL and testbench
===============================

FP_NORM_PACK -- requirements
Module: fp_norm_pack

Interface
REQ-001 Parameter MAN_W, default 11, SHALL be the mantissa width including the hidden bit (hidden bit = in_man[MAN_W-1]).
REQ-002 Parameter IN_EXP_W, default 6, SHALL be the width of the unpacked biased exponent from the adder/subtractor stage.
REQ-003 Parameter OUT_EXP_W, default 5, SHALL be the packed exponent field width; packed word width = 1+OUT_EXP_W+MAN_W-1 (16 at defaults), EMAX = 2^OUT_EXP_W-1 (31).
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 Ports: clk  in  1  clock, all state on rising edge.
REQ-006 Ports: rst  in  1  synchronous active-high reset.
REQ-007 Ports: in_valid  in  1  adder result present; in_ready  out  1  block can accept.
REQ-008 Ports: in_sgn  in  1 / in_man  in  MAN_W / in_exp  in  IN_EXP_W  unnormalized sign, mantissa, biased exponent (bias 15) from the adder/subtractor stage.
REQ-009 Ports: out_valid  out  1; out_ready  in  1  downstream accepts.
REQ-010 Ports: out_word  out  16  packed half-precision {sign, exp[4:0], frac[9:0]}.
REQ-011 Ports: out_ovf / out_zero / out_sub  out  1 each  overflow-to-infinity, zero, subnormal result flags.

Function
REQ-012 FSM states IDLE, NORM, DONE; in_ready SHALL be 1 only in IDLE.
REQ-013 IDLE: on in_valid&in_ready, register sgn, man, exp (exp 0 loaded as 1) and go to NORM; otherwise stay.
REQ-014 NORM, terminal condition = man==0, or man[MAN_W-1]==1, or exp<=1.
REQ-015 NORM, non-terminal: one-bit left shift of man and exp-1 per cycle; no other change.
REQ-016 NORM, terminal: compute result into output registers, go to DONE (out_valid=1 after that edge).
REQ-017 Latency SHALL be s+1 cycles from accept edge to out_valid, s = shifts performed (0..MAN_W-1); max 11 at defaults.
REQ-018 Pack, zero: man==0 -> out_word = {sgn,15'b0}, out_zero=1.
REQ-019 Pack, overflow: exp>=EMAX with man nonzero -> out_word = {sgn,5'b11111,10'b0}, out_ovf=1.
REQ-020 Pack, subnormal: man[MAN_W-1]==0 -> exp field 0, frac = man[9:0], out_sub=1.
REQ-021 Pack, normal: {sgn, exp[4:0], man[9:0]}, all flags 0; no rounding (no bits discarded by left shift).
REQ-022 Flags SHALL be mutually exclusive.
REQ-023 DONE: outputs held stable while out_ready=0; on out_ready=1 go to IDLE, out_valid=0 next cycle.
REQ-024 Throughput SHALL be one result per s+3 cycles minimum; no input accepted in NORM or DONE.
REQ-025 in_* changes while in_ready=0 SHALL have no effect.

Reset
REQ-026 rst=1 at a rising edge SHALL force IDLE, out_valid=0, out_word=0, all flags 0, internal registers 0, in_ready=1 from the following cycle.
REQ-027 rst SHALL take priority over every FSM transition, including mid-NORM and DONE with out_ready=1; the in-flight result SHALL be discarded with no out_valid pulse.

Verification
REQ-028 sgn0, man 11'b11000000000, exp 17, out_ready=1 -> out_word 0x4600, flags 0, out_valid 1 cycle after accept.
REQ-029 sgn0, man 11'b00001100000, exp 17 -> 4 shifts, out_word 0x3600, out_valid 5 cycles after accept.
REQ-030 sgn0, man 11'b00001100000, exp 3 -> 2 shifts, out_word 0x0180, out_sub=1, latency 3.
REQ-031 Overflow/zero: sgn1, man 11'b10000000000, exp 31 -> 0xFC00, out_ovf=1; sgn1, man 0, exp 9 -> 0x8000, out_zero=1, latency 1.
REQ-032 Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_word/flags/out_valid unchanged, in_ready=0; release -> IDLE next cycle.
REQ-033 Reset mid-NORM: pulse rst during the 2nd shift of REQ-029 -> no out_valid, in_ready=1 after reset; next operand processes normally.

Source files
------------

// File: rtl/fp_norm_pack_if.sv
// Handshake bus between the adder/subtractor stage, the normalise/pack block and its consumer.
// The slave side is the fp_norm_pack block; the master side drives operands and takes results.
interface fp_norm_pack_if #(
    parameter int MAN_W     = 11,
    parameter int IN_EXP_W  = 6,
    parameter int OUT_EXP_W = 5
);
    localparam int WORD_W = 1 + OUT_EXP_W + MAN_W - 1;

    logic                in_valid;
    logic                in_ready;
    logic                in_sgn;
    logic [MAN_W-1:0]    in_man;
    logic [IN_EXP_W-1:0] in_exp;

    logic                out_valid;
    logic                out_ready;
    logic [WORD_W-1:0]   out_word;
    logic                out_ovf;
    logic                out_zero;
    logic                out_sub;

    modport slave (
        input  in_valid, in_sgn, in_man, in_exp, out_ready,
        output in_ready, out_valid, out_word, out_ovf, out_zero, out_sub
    );

    modport master (
        output in_valid, in_sgn, in_man, in_exp, out_ready,
        input  in_ready, out_valid, out_word, out_ovf, out_zero, out_sub
    );
endinterface

// File: rtl/fp_norm_pack.sv
// Iterative left-normaliser and half-precision packer for an unnormalised adder result.
// One shift per cycle until the hidden bit is set, the mantissa is zero or the exponent bottoms out.
module fp_norm_pack #(
    parameter int MAN_W     = 11,
    parameter int IN_EXP_W  = 6,
    parameter int OUT_EXP_W = 5
) (
    input logic             clk,
    input logic             rst,
    fp_norm_pack_if.slave   bus
);
    localparam int WORD_W = 1 + OUT_EXP_W + MAN_W - 1;
    localparam int EMAX   = (2 ** OUT_EXP_W) - 1;

    typedef enum logic [1:0] {StIdle, StNorm, StDone} state_e;

    state_e              state_q, state_d;
    logic                sgn_q, sgn_d;
    logic [MAN_W-1:0]    man_q, man_d;
    logic [IN_EXP_W-1:0] exp_q, exp_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic                ovf_q, ovf_d;
    logic                zero_q, zero_d;
    logic                sub_q, sub_d;
    logic                terminal;

    assign terminal = (man_q == '0) || man_q[MAN_W-1] || (exp_q <= IN_EXP_W'(1));

    always_comb begin
        state_d = state_q;
        sgn_d   = sgn_q;
        man_d   = man_q;
        exp_d   = exp_q;
        word_d  = word_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        sub_d   = sub_q;

        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    sgn_d   = bus.in_sgn;
                    man_d   = bus.in_man;
                    // A zero exponent is treated as the subnormal exponent 1.
                    exp_d   = (bus.in_exp == '0) ? IN_EXP_W'(1) : bus.in_exp;
                    state_d = StNorm;
                end
            end
            StNorm: begin
                if (terminal) begin
                    ovf_d   = 1'b0;
                    zero_d  = 1'b0;
                    sub_d   = 1'b0;
                    state_d = StDone;
                    if (man_q == '0) begin
                        word_d = {sgn_q, {(WORD_W-1){1'b0}}};
                        zero_d = 1'b1;
                    end else if (exp_q >= IN_EXP_W'(EMAX)) begin
                        word_d = {sgn_q, {OUT_EXP_W{1'b1}}, {(MAN_W-1){1'b0}}};
                        ovf_d  = 1'b1;
                    end else if (!man_q[MAN_W-1]) begin
                        word_d = {sgn_q, {OUT_EXP_W{1'b0}}, man_q[MAN_W-2:0]};
                        sub_d  = 1'b1;
                    end else begin
                        word_d = {sgn_q, exp_q[OUT_EXP_W-1:0], man_q[MAN_W-2:0]};
                    end
                end else begin
                    man_d = man_q << 1;
                    exp_d = exp_q - IN_EXP_W'(1);
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            sgn_q   <= 1'b0;
            man_q   <= '0;
            exp_q   <= '0;
            word_q  <= '0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            sub_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sgn_q   <= sgn_d;
            man_q   <= man_d;
            exp_q   <= exp_d;
            word_q  <= word_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            sub_q   <= sub_d;
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.out_word  = word_q;
    assign bus.out_ovf   = ovf_q;
    assign bus.out_zero  = zero_q;
    assign bus.out_sub   = sub_q;
endmodule

// File: tb/tb_fp_norm_pack.sv
// Directed and pseudo-random bench for fp_norm_pack with a queue of expected results.
// Flags are compared as {ovf, zero, sub}.
module tb_fp_norm_pack;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   passed = 0;

    typedef struct {
        logic [15:0] word;
        logic [2:0]  flags;
        int          lat;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    fp_norm_pack_if bus ();

    fp_norm_pack dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        checks++;
        assert (obs === req) passed++;
        else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, req);
    endtask

    // Independent reference: normalise by repeated shifting, then pack.
    task automatic model(input logic s, input logic [10:0] man, input logic [5:0] ex,
                         output logic [15:0] w, output logic [2:0] f, output int lat);
        logic [10:0] m;
        int          e;
        m   = man;
        e   = (ex == 0) ? 1 : int'(ex);
        lat = 1;
        while (m != 0 && !m[10] && e > 1) begin
            m = m << 1;
            e = e - 1;
            lat++;
        end
        if (m == 0) begin
            w = {s, 15'h0};
            f = 3'b010;
        end else if (e >= 31) begin
            w = {s, 5'h1f, 10'h0};
            f = 3'b100;
        end else if (!m[10]) begin
            w = {s, 5'h0, m[9:0]};
            f = 3'b001;
        end else begin
            w = {s, e[4:0], m[9:0]};
            f = 3'b000;
        end
    endtask

    task automatic drive(input logic s, input logic [10:0] man, input logic [5:0] ex,
                         input logic [15:0] w, input logic [2:0] f, input int lat);
        exp_t e;
        int   n;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
        e.word  = w;
        e.flags = f;
        e.lat   = lat;
        sb_q.push_back(e);
        bus.in_valid = 1'b1;
        bus.in_sgn   = s;
        bus.in_man   = man;
        bus.in_exp   = ex;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        // Scramble operands while busy; they must not leak into the result.
        bus.in_sgn   = ~s;
        bus.in_man   = 11'($urandom);
        bus.in_exp   = 6'($urandom);
        chk("in_ready_after_accept", 32'(bus.in_ready), 32'd0);
    endtask

    task automatic collect(input int hold);
        exp_t        e;
        int          lat;
        logic [15:0] w0;
        logic [2:0]  f0;
        bus.out_ready = (hold == 0);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (sb_q.size() == 0) begin
            chk("scoreboard_nonempty", 32'(sb_q.size()), 32'd1);
            return;
        end
        e = sb_q.pop_front();
        chk("latency", 32'(lat), 32'(e.lat));
        chk("out_word", 32'(bus.out_word), 32'(e.word));
        chk("flags", 32'({bus.out_ovf, bus.out_zero, bus.out_sub}), 32'(e.flags));
        w0 = bus.out_word;
        f0 = {bus.out_ovf, bus.out_zero, bus.out_sub};
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'b1;
            @(posedge clk);
            #1;
            chk("hold_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_word", 32'(bus.out_word), 32'(w0));
            chk("hold_flags", 32'({bus.out_ovf, bus.out_zero, bus.out_sub}), 32'(f0));
            chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("valid_drop", 32'(bus.out_valid), 32'd0);
        chk("idle_in_ready", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        logic [15:0] w;
        logic [2:0]  f;
        logic [10:0] m;
        logic [5:0]  ex;
        logic        s;
        int          lat;
        int          pulses;

        bus.in_valid  = 1'b0;
        bus.in_sgn    = 1'b0;
        bus.in_man    = '0;
        bus.in_exp    = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_word", 32'(bus.out_word), 32'd0);
        chk("rst_flags", 32'({bus.out_ovf, bus.out_zero, bus.out_sub}), 32'd0);

        drive(1'b0, 11'b11000000000, 6'd17, 16'h4600, 3'b000, 1);  collect(0);
        drive(1'b0, 11'b00001100000, 6'd17, 16'h3600, 3'b000, 5);  collect(0);
        drive(1'b0, 11'b00001100000, 6'd3,  16'h0180, 3'b001, 3);  collect(0);
        drive(1'b1, 11'b10000000000, 6'd31, 16'hFC00, 3'b100, 1);  collect(0);
        drive(1'b1, 11'b00000000000, 6'd9,  16'h8000, 3'b010, 1);  collect(0);
        drive(1'b0, 11'b00000000001, 6'd0,  16'h0001, 3'b001, 1);  collect(0);
        drive(1'b0, 11'b00000000001, 6'd20, 16'h2800, 3'b000, 11); collect(0);
        drive(1'b0, 11'b01000000000, 6'd40, 16'h7C00, 3'b100, 2);  collect(0);
        drive(1'b0, 11'b10101010101, 6'd30, 16'h7955, 3'b000, 1);  collect(0);

        // Backpressure for five cycles in DONE.
        drive(1'b0, 11'b11000000000, 6'd17, 16'h4600, 3'b000, 1);  collect(5);

        // Reset asserted across the second shift edge discards the in-flight result.
        drive(1'b0, 11'b00001100000, 6'd17, 16'h3600, 3'b000, 5);
        void'(sb_q.pop_back());
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("midrst_out_word", 32'(bus.out_word), 32'd0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.out_valid) pulses++;
            @(posedge clk);
            #1;
        end
        chk("midrst_no_valid", 32'(pulses), 32'd0);
        drive(1'b0, 11'b00001100000, 6'd17, 16'h3600, 3'b000, 5);  collect(0);

        for (int i = 0; i < 8; i++) begin
            s  = 1'($urandom);
            m  = 11'($urandom) >> $urandom_range(0, 10);
            ex = 6'($urandom_range(0, 63));
            model(s, m, ex, w, f, lat);
            drive(s, m, ex, w, f, lat);
            collect(i % 3);
        end

        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
